// File: rtl/rx_deframer_pkg.sv
// Shared frame layout, verdict codes and FSM states for the receive deframer.
// The field positions must stay in step with the transmit framer.
package rx_deframer_pkg;

  localparam int PAYLOAD_W  = 512;
  localparam int FRAME_W    = PAYLOAD_W + 26;
  localparam int MAC_DATA_W = PAYLOAD_W + 18;

  localparam int PAYLOAD_MSB = FRAME_W - 1;
  localparam int PAYLOAD_LSB = 26;
  localparam int CNT_MSB     = 25;
  localparam int CNT_LSB     = 18;
  localparam int TIMER_MSB   = 17;
  localparam int TIMER_LSB   = 10;
  localparam int TAG_MSB     = 9;
  localparam int TAG_LSB     = 2;
  localparam int STATE_MSB   = 1;
  localparam int STATE_LSB   = 0;

  localparam int CNT_WIN_DEF     = 16;
  localparam int TIME_WIN_DEF    = 4;
  localparam int MAC_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_OK          = 3'd0,
    ST_REPLAY      = 3'd1,
    ST_STALE       = 3'd2,
    ST_BAD_TAG     = 3'd3,
    ST_MAC_TIMEOUT = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MAC_WAIT = 2'd1,
    S_CHECK    = 2'd2,
    S_OUT      = 2'd3
  } fsm_e;

endpackage

// File: rtl/rx_deframer_if.sv
// Bundle of the frame input, MAC-engine request/ack and result handshake.
interface rx_deframer_if;
  import rx_deframer_pkg::*;

  logic [FRAME_W-1:0]    frame_in;
  logic                  frame_valid;
  logic                  frame_ready;
  logic [7:0]            local_time;
  logic                  mac_req;
  logic [MAC_DATA_W-1:0] mac_data;
  logic                  mac_ack;
  logic [7:0]            mac_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [PAYLOAD_W-1:0]  payload_out;
  logic [1:0]            state_out;
  logic [2:0]            status;
  logic [7:0]            err_count;

  modport slave (
    input  frame_in, frame_valid, local_time, mac_ack, mac_tag, out_ready,
    output frame_ready, mac_req, mac_data, out_valid, payload_out, state_out,
           status, err_count
  );

  modport master (
    output frame_in, frame_valid, local_time, mac_ack, mac_tag, out_ready,
    input  frame_ready, mac_req, mac_data, out_valid, payload_out, state_out,
           status, err_count
  );

endinterface

// File: rtl/rx_freshness_check.sv
// Combinational replay-window and timer-window checks for a received frame.
module rx_freshness_check #(
  parameter int CNT_WIN  = 16,
  parameter int TIME_WIN = 4
) (
  input  logic [7:0] rx_cnt,
  input  logic [7:0] last_cnt,
  input  logic       have_last,
  input  logic [7:0] rx_timer,
  input  logic [7:0] local_time,
  output logic       cnt_ok,
  output logic       time_ok
);

  logic [7:0] cnt_delta;
  logic [7:0] time_delta;

  // Both differences wrap mod 256, so a counter rollover still reads as +1.
  assign cnt_delta  = rx_cnt - last_cnt;
  assign time_delta = local_time - rx_timer;

  assign cnt_ok  = !have_last || ((cnt_delta != 8'd0) && (cnt_delta <= 8'(CNT_WIN)));
  assign time_ok = (time_delta <= 8'(TIME_WIN)) || (time_delta >= 8'(256 - TIME_WIN));

endmodule

// File: rtl/rx_deframer.sv
// Receive deframer: captures a frame, fetches a reference tag from the MAC
// engine, checks authenticity and freshness, and hands payload plus verdict on.
//   state    | meaning
//   IDLE     | ready for a frame
//   MAC_WAIT | tag request outstanding, timeout running
//   CHECK    | one cycle to form the verdict
//   OUT      | result presented until the consumer takes it
module rx_deframer
  import rx_deframer_pkg::*;
#(
  parameter int CNT_WIN     = CNT_WIN_DEF,
  parameter int TIME_WIN    = TIME_WIN_DEF,
  parameter int MAC_TIMEOUT = MAC_TIMEOUT_DEF
) (
  input logic          clk,
  input logic          resetN,
  rx_deframer_if.slave bus
);

  localparam int TMO_W = $clog2(MAC_TIMEOUT + 1);

  fsm_e                 state, state_nxt;
  logic                 alive;
  logic [PAYLOAD_W-1:0] rx_payload;
  logic [7:0]           rx_cnt, rx_timer, rx_tag, tag_q;
  logic [1:0]           rx_state;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 tmo_hit;
  logic [7:0]           last_cnt;
  logic                 have_last;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [1:0]           state_q;
  status_e              status_q, verdict;
  logic [7:0]           err_q;
  logic                 cnt_ok, time_ok, enter_out;

  rx_freshness_check #(.CNT_WIN(CNT_WIN), .TIME_WIN(TIME_WIN)) u_fresh (
    .rx_cnt    (rx_cnt),
    .last_cnt  (last_cnt),
    .have_last (have_last),
    .rx_timer  (rx_timer),
    .local_time(bus.local_time),
    .cnt_ok    (cnt_ok),
    .time_ok   (time_ok)
  );

  assign tmo_hit = (tmo_cnt == TMO_W'(MAC_TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (bus.frame_valid && alive) state_nxt = S_MAC_WAIT;
      S_MAC_WAIT: if (bus.mac_ack)              state_nxt = S_CHECK;
                  else if (tmo_hit)             state_nxt = S_OUT;
      S_CHECK:                                  state_nxt = S_OUT;
      S_OUT:      if (bus.out_ready)            state_nxt = S_IDLE;
      default:                                  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.frame_ready = (state == S_IDLE) && alive;
    bus.mac_req     = (state == S_MAC_WAIT);
    bus.out_valid   = (state == S_OUT);
  end

  // Tag mismatch outranks replay, which outranks staleness.
  always_comb begin
    verdict = ST_OK;
    if (state == S_MAC_WAIT)   verdict = ST_MAC_TIMEOUT;
    else if (rx_tag != tag_q)  verdict = ST_BAD_TAG;
    else if (!cnt_ok)          verdict = ST_REPLAY;
    else if (!time_ok)         verdict = ST_STALE;
  end

  assign enter_out = (state == S_CHECK) ||
                     ((state == S_MAC_WAIT) && !bus.mac_ack && tmo_hit);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rx_payload <= '0;
      rx_cnt     <= '0;
      rx_timer   <= '0;
      rx_tag     <= '0;
      rx_state   <= '0;
      tag_q      <= '0;
      tmo_cnt    <= '0;
    end else if (bus.frame_ready && bus.frame_valid) begin
      rx_payload <= bus.frame_in[PAYLOAD_MSB:PAYLOAD_LSB];
      rx_cnt     <= bus.frame_in[CNT_MSB:CNT_LSB];
      rx_timer   <= bus.frame_in[TIMER_MSB:TIMER_LSB];
      rx_tag     <= bus.frame_in[TAG_MSB:TAG_LSB];
      rx_state   <= bus.frame_in[STATE_MSB:STATE_LSB];
      tmo_cnt    <= '0;
    end else if (state == S_MAC_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      if (bus.mac_ack) tag_q <= bus.mac_tag;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_cnt  <= '0;
      have_last <= 1'b0;
      payload_q <= '0;
      state_q   <= '0;
      status_q  <= ST_OK;
      err_q     <= '0;
    end else if (enter_out) begin
      status_q <= verdict;
      state_q  <= rx_state;
      if (verdict == ST_OK) begin
        payload_q <= rx_payload;
        last_cnt  <= rx_cnt;
        have_last <= 1'b1;
      end else begin
        payload_q <= '0;
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
    end
  end

  assign bus.mac_data    = {rx_payload, rx_cnt, rx_timer, rx_state};
  assign bus.payload_out = payload_q;
  assign bus.state_out   = state_q;
  assign bus.status      = status_q;
  assign bus.err_count   = err_q;

endmodule

// File: tb/tb_rx_deframer.sv
// Self-checking bench for rx_deframer: vector table plus timeout/reset sequences.
module tb_rx_deframer;
  import rx_deframer_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  rx_deframer_if bus();
  rx_deframer dut (.clk(clk), .resetN(resetN), .bus(bus));

  typedef struct {
    logic [7:0] cnt, timer, tag;
    logic [1:0] st;
    logic [7:0] lt, mtag;
    int         ack_dly;
    logic [2:0] exp_status;
  } vec_t;

  typedef struct {
    logic [2:0]           status;
    logic [PAYLOAD_W-1:0] payload;
    logic [1:0]           st;
    logic [7:0]           err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks = 0;
  int   failures = 0;
  int   exp_err = 0;

  task automatic chk(input string name, input logic [MAC_DATA_W-1:0] act,
                     input logic [MAC_DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PAYLOAD_W-1:0] rand_pl();
    logic [PAYLOAD_W-1:0] r;
    for (int i = 0; i < PAYLOAD_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic push_exp(input logic [PAYLOAD_W-1:0] pl, input logic [2:0] s,
                          input logic [1:0] st);
    exp_t e;
    if (s != 3'd0) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    e.status  = s;
    e.payload = (s == 3'd0) ? pl : '0;
    e.st      = st;
    e.err     = 8'(exp_err);
    sb.push_back(e);
  endtask

  task automatic collect;
    exp_t e;
    int   n = 0;
    while (!bus.out_valid && n < 100) begin
      tick;
      n++;
    end
    chk("out_valid_seen", bus.out_valid, 1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_underflow: got output, expected none");
      return;
    end
    e = sb.pop_front();
    chk("status", bus.status, e.status);
    chk("payload_out", bus.payload_out, e.payload);
    chk("state_out", bus.state_out, e.st);
    chk("err_count", bus.err_count, e.err);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
    chk("frame_ready_back", bus.frame_ready, 1);
  endtask

  task automatic send(input vec_t v);
    logic [PAYLOAD_W-1:0] pl;
    pl = rand_pl();
    bus.local_time = v.lt;
    chk("frame_ready_idle", bus.frame_ready, 1);
    bus.frame_in    = {pl, v.cnt, v.timer, v.tag, v.st};
    bus.frame_valid = 1'b1;
    push_exp(pl, v.exp_status, v.st);
    tick;
    bus.frame_valid = 1'b0;
    chk("mac_req_rise", bus.mac_req, 1);
    chk("mac_data", bus.mac_data, {pl, v.cnt, v.timer, v.st});
    for (int i = 0; i < v.ack_dly; i++) begin
      tick;
      chk("mac_req_held", bus.mac_req, 1);
    end
    bus.mac_ack = 1'b1;
    bus.mac_tag = v.mtag;
    tick;
    bus.mac_ack = 1'b0;
    chk("mac_req_drop", bus.mac_req, 0);
    chk("no_early_valid", bus.out_valid, 0);
    tick;
    chk("out_valid_latency", bus.out_valid, 1);
    collect();
  endtask

  initial begin
    logic [PAYLOAD_W-1:0] pl;
    int n;

    vecs[0]  = '{8'h05, 8'h10, 8'h3C, 2'b01, 8'h11, 8'h3C, 2, ST_OK};
    vecs[1]  = '{8'h05, 8'h10, 8'h3C, 2'b01, 8'h11, 8'h3C, 2, ST_REPLAY};
    vecs[2]  = '{8'h06, 8'hFE, 8'h77, 2'b10, 8'h02, 8'h77, 0, ST_OK};
    vecs[3]  = '{8'h07, 8'hFA, 8'h77, 2'b11, 8'h02, 8'h77, 1, ST_STALE};
    vecs[4]  = '{8'h05, 8'h10, 8'h5A, 2'b00, 8'h11, 8'hA5, 3, ST_BAD_TAG};
    vecs[5]  = '{8'h16, 8'h40, 8'hC3, 2'b01, 8'h40, 8'hC3, 0, ST_OK};
    vecs[6]  = '{8'h27, 8'h40, 8'hC3, 2'b10, 8'h40, 8'hC3, 1, ST_REPLAY};
    vecs[7]  = '{8'h17, 8'h84, 8'h99, 2'b11, 8'h80, 8'h99, 2, ST_OK};
    vecs[8]  = '{8'h18, 8'h7B, 8'h99, 2'b00, 8'h80, 8'h99, 0, ST_STALE};
    vecs[9]  = '{8'hFF, 8'h33, 8'h12, 2'b01, 8'h33, 8'h12, 1, ST_OK};
    vecs[10] = '{8'h00, 8'h33, 8'h12, 2'b10, 8'h35, 8'h12, 0, ST_OK};
    vecs[11] = '{8'h20, 8'h33, 8'h12, 2'b11, 8'h33, 8'h12, 2, ST_REPLAY};

    bus.frame_in    = '0;
    bus.frame_valid = 1'b0;
    bus.local_time  = '0;
    bus.mac_ack     = 1'b0;
    bus.mac_tag     = '0;
    bus.out_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_ready", bus.frame_ready, 0);
    chk("rst_mac_req", bus.mac_req, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_payload", bus.payload_out, 0);
    resetN = 1'b1;
    tick;

    // A stray ack while idle must not start anything.
    bus.mac_ack = 1'b1;
    bus.mac_tag = 8'h3C;
    tick;
    bus.mac_ack = 1'b0;
    chk("stray_ack_mac_req", bus.mac_req, 0);
    chk("stray_ack_out_valid", bus.out_valid, 0);

    for (int i = 0; i <= 8; i++) send(vecs[i]);

    // No ack: request held for the full timeout window.
    pl = rand_pl();
    bus.local_time  = 8'h80;
    bus.frame_in    = {pl, 8'h19, 8'h80, 8'h44, 2'b11};
    bus.frame_valid = 1'b1;
    push_exp(pl, ST_MAC_TIMEOUT, 2'b11);
    tick;
    bus.frame_valid = 1'b0;
    n = 0;
    while (bus.mac_req && n < 200) begin
      n++;
      tick;
    end
    chk("mac_req_hold_cycles", 32'(n), 64);
    chk("timeout_out_valid", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_status", bus.status, ST_MAC_TIMEOUT);
      chk("stall_payload", bus.payload_out, 0);
      chk("stall_mac_req", bus.mac_req, 0);
    end
    collect();

    // Reset while waiting on the MAC engine.
    bus.frame_in    = {rand_pl(), 8'h1A, 8'h80, 8'h44, 2'b01};
    bus.frame_valid = 1'b1;
    tick;
    bus.frame_valid = 1'b0;
    tick;
    chk("pre_reset_mac_req", bus.mac_req, 1);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_rst_mac_req", bus.mac_req, 0);
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_err_count", bus.err_count, 0);
    exp_err = 0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    tick;

    for (int i = 9; i <= 11; i++) send(vecs[i]);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_deframer.md
Name: rx_deframer

Overview:
- Receive-side counterpart of the transmit framer.
- Accepts a 538-bit authenticated frame, splits it into payload, message counter, timestamp, auth tag and state bits.
- Requests a reference tag from the external MAC engine and checks freshness (counter replay window, timer window) and authenticity.
- Emits payload plus a verdict to the downstream consumer; sits between the link receiver and the application.

Parameters:
- PAYLOAD_W, 512, payload width; frame width = PAYLOAD_W+26.
- CNT_WIN, 16, maximum forward jump of message counter accepted.
- TIME_WIN, 4, maximum absolute difference (mod 256) between rx timer and local_time.
- MAC_TIMEOUT, 64, cycles to wait for mac_ack before aborting.

Ports:
- clk, input, 1, system clock.
- resetN, input, 1, asynchronous active-low reset.
- frame_in, input, 538, frame: [537:26] payload, [25:18] msg_counter, [17:10] timer, [9:2] auth_tag, [1:0] state_bits.
- frame_valid, input, 1, frame_in valid.
- frame_ready, output, 1, deframer can capture a frame.
- local_time, input, 8, receiver's synchronized timer.
- mac_req, output, 1, tag request, level-held until ack.
- mac_data, output, 530, {payload, msg_counter, timer, state_bits} of the captured frame.
- mac_ack, input, 1, single-cycle pulse; mac_tag valid this cycle.
- mac_tag, input, 8, reference tag.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- payload_out, output, 512, accepted payload; zero on any reject.
- state_out, output, 2, received state_bits.
- status, output, 3, 0 OK, 1 REPLAY, 2 STALE, 3 BAD_TAG, 4 MAC_TIMEOUT.
- err_count, output, 8, saturating count of rejected frames.

Behaviour:
- Reset (async, resetN low): all outputs 0, FSM IDLE, last_cnt=0, have_last=0, err_count=0, timeout counter 0.
- FSM IDLE -> MAC_WAIT -> CHECK -> OUT -> IDLE.
- IDLE:
  - frame_ready=1.
  - frame_valid&&frame_ready captures fields into registers; next state MAC_WAIT.
  - frame_ready=0 in all other states.
- MAC_WAIT:
  - mac_req=1, mac_data driven from captured registers, stable throughout.
  - On mac_ack: latch mac_tag, drop mac_req the next cycle, go CHECK.
  - Timeout counter increments per MAC_WAIT cycle. Reaching MAC_TIMEOUT without ack sets the verdict to MAC_TIMEOUT, drops mac_req and goes OUT.
  - mac_ack outside MAC_WAIT is ignored.
- CHECK (1 cycle): compute the verdict, first failing check wins, in this order: BAD_TAG (rx auth_tag != mac_tag), REPLAY, STALE, else OK.
  - Counter check: delta=(rx_cnt-last_cnt) mod 256. Pass if 1<=delta<=CNT_WIN. If have_last=0, any counter passes.
  - Timer check: d=(local_time-rx_timer) mod 256, local_time sampled in CHECK. Pass if d<=TIME_WIN or d>=256-TIME_WIN.
- OUT:
  - out_valid=1; payload_out, state_out, status held stable until out_valid&&out_ready, then IDLE (frame_ready=1 next cycle).
  - On OK: last_cnt<=rx_cnt, have_last<=1.
  - On reject: payload_out=0, last_cnt unchanged, err_count+1 saturating at 255.
  - Counter/err updates happen once, on OUT entry.
- Latency: capture at cycle N; mac_req high N+1. If mac_ack arrives at cycle M, CHECK runs at M+1 and out_valid rises at M+2. Minimum capture-to-out_valid is 3 cycles.
- Counter wrap: last_cnt 0xFF with rx 0x00 gives delta=1 and is accepted.
- Reset mid-operation aborts immediately: mac_req and out_valid drop, captured frame discarded, replay history cleared.

Decomposition:
- Package rx_deframer_pkg holds:
  - FRAME_W and the field LSB/MSB constants, shared with the framer.
  - Status enum.
  - FSM state enum.
- One combinational sub-module, rx_freshness_check: inputs rx_cnt, last_cnt, have_last, rx_timer, local_time; outputs cnt_ok, time_ok.

Test Plan:
- Reset, then frame cnt=0x05 timer=0x10 tag=0x3C state=2'b01, local_time=0x11, mac_ack with tag 0x3C 2 cycles after mac_req -> out_valid at ack+2, status 0, payload_out=frame payload, state_out=01.
- Resend identical frame -> status 1 REPLAY, payload_out=0, err_count=1, last_cnt stays 0x05.
- Accepted cnt 0xFF then cnt 0x00 -> OK. Then cnt 0x20 (delta 0x20>16) -> REPLAY.
- local_time=0x02: rx timer 0xFE -> OK (d=4); rx timer 0xFA -> STALE (d=8).
- mac_tag 0xA5 vs rx tag 0x5A, with a replayed counter -> BAD_TAG (priority over REPLAY).
- No mac_ack -> mac_req held 64 cycles, then status 4, mac_req low. Hold out_ready=0 for 5 cycles -> outputs stable. Pulse resetN low during MAC_WAIT -> mac_req and out_valid 0 asynchronously, err_count 0.
